// File: rtl/alu_logic_responder.sv
// ARM logic-op responder (AND/ORR/EOR/BIC + N/Z): result is valid the cycle after accept.
// Output register + skid register absorb one stalled cycle; req_ready drops only when the skid is occupied.
module alu_logic_responder #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic             rsp_n,
    output logic             rsp_z,
    output logic [CNT_W-1:0] rsp_count
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ORR = 2'b01;
    localparam logic [1:0] OP_EOR = 2'b10;
    localparam logic [1:0] OP_BIC = 2'b11;

    typedef struct packed {
        logic         n;
        logic         z;
        logic [N-1:0] res;
    } rsp_t;

    logic             r_out_vld;
    logic             r_skid_vld;
    rsp_t             r_out_dat;
    rsp_t             r_skid_dat;
    logic [CNT_W-1:0] r_count;

    logic [N-1:0]     w_res;
    rsp_t             w_new_dat;
    logic             w_acc;
    logic             w_xfer;

    always_comb begin
        w_res = '0;
        case (req_op)
            OP_AND:  w_res = req_a & req_b;
            OP_ORR:  w_res = req_a | req_b;
            OP_EOR:  w_res = req_a ^ req_b;
            OP_BIC:  w_res = req_a & ~req_b;
            default: w_res = '0;
        endcase
    end

    assign w_new_dat.res = w_res;
    assign w_new_dat.n   = w_res[N-1];
    assign w_new_dat.z   = (w_res == '0);

    // Ready is a function of registered state only, so there is no req_valid -> req_ready path.
    assign req_ready = rst_n & ~r_skid_vld;
    assign w_acc     = req_valid & req_ready;
    assign w_xfer    = r_out_vld & rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_out_dat  <= '0;
            r_skid_dat <= '0;
            r_count    <= '0;
        end else begin
            if (w_xfer) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_skid_vld) begin
                // FULL: the only way out is a transfer, which promotes the skid entry.
                if (w_xfer) begin
                    r_out_dat  <= r_skid_dat;
                    r_skid_vld <= 1'b0;
                end
            end else if (w_acc) begin
                if (!r_out_vld || w_xfer) begin
                    r_out_dat <= w_new_dat;
                    r_out_vld <= 1'b1;
                end else begin
                    r_skid_dat <= w_new_dat;
                    r_skid_vld <= 1'b1;
                end
            end else if (w_xfer) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign rsp_valid  = r_out_vld;
    assign rsp_result = r_out_dat.res;
    assign rsp_n      = r_out_dat.n;
    assign rsp_z      = r_out_dat.z;
    assign rsp_count  = r_count;

endmodule

// File: tb/tb_alu_logic_responder.sv
// Directed-vector bench for alu_logic_responder: handshake, ops, flags, skid ordering, counter wrap, reset.
module tb_alu_logic_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_n;
    logic        rsp_z;
    logic [7:0]  rsp_count;

    int tests_run;
    int tests_failed;
    int exp_cnt;

    alu_logic_responder #(.N(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .rsp_count  (rsp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'h0000_00AA;
        req_b     = 32'h0;
        rsp_ready = 1'b0;
        step();
        step();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        tests_run++;
        if (rsp_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d want 0", rsp_count);
        end
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_ready_low: got %b want 0", req_ready);
        end
        tests_run++;
        if (rsp_result !== 32'h0 || rsp_n !== 1'b0 || rsp_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h n=%b z=%b want 0 n=0 z=0", rsp_result, rsp_n, rsp_z);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        exp_cnt = 0;
    endtask

    task automatic test_orr_basic();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'h0000_0002;
        req_b     = 32'h0000_0001;
        step();
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_0003 || rsp_n !== 1'b0 || rsp_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL orr_basic: got v=%b %h n=%b z=%b want v=1 00000003 n=0 z=0",
                     rsp_valid, rsp_result, rsp_n, rsp_z);
        end
        step();
        exp_cnt++;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_count !== 8'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL orr_basic_drain: got v=%b cnt=%0d want v=0 cnt=%0d", rsp_valid, rsp_count, exp_cnt);
        end
    endtask

    task automatic test_logic_ops();
        logic [1:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] rs  [4];
        logic        ns  [4];
        logic        zs  [4];
        ops[0] = 2'b01; as[0] = 32'h5555_5555; bs[0] = 32'h2222_2222; rs[0] = 32'h7777_7777; ns[0] = 0; zs[0] = 0;
        ops[1] = 2'b00; as[1] = 32'h0000_000F; bs[1] = 32'h0000_00F0; rs[1] = 32'h0000_0000; ns[1] = 0; zs[1] = 1;
        ops[2] = 2'b10; as[2] = 32'h8000_0000; bs[2] = 32'h0000_0000; rs[2] = 32'h8000_0000; ns[2] = 1; zs[2] = 0;
        ops[3] = 2'b11; as[3] = 32'hFFFF_FFFF; bs[3] = 32'h0000_FFFF; rs[3] = 32'hFFFF_0000; ns[3] = 1; zs[3] = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_op    = ops[i];
            req_a     = as[i];
            req_b     = bs[i];
            step();
            req_valid = 1'b0;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_result !== rs[i] || rsp_n !== ns[i] || rsp_z !== zs[i]) begin
                tests_failed++;
                $display("FAIL logic_op[%0d]: got v=%b %h n=%b z=%b want v=1 %h n=%b z=%b",
                         i, rsp_valid, rsp_result, rsp_n, rsp_z, rs[i], ns[i], zs[i]);
            end
            step();
            exp_cnt++;
        end
        tests_run++;
        if (rsp_count !== 8'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL logic_ops_count: got %0d want %0d", rsp_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        req_op    = 2'b01;
        req_b     = 32'h0;
        req_valid = 1'b1;
        req_a     = 32'h1;
        step();
        req_a = 32'h2;
        step();
        req_a = 32'h4;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_full_ready: got %b want 0", req_ready);
        end
        step();
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h1 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_stall_hold: got v=%b %h rdy=%b want v=1 00000001 rdy=0",
                     rsp_valid, rsp_result, req_ready);
        end
        rsp_ready = 1'b1;
        step();
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h2 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: got v=%b %h rdy=%b want v=1 00000002 rdy=1",
                     rsp_valid, rsp_result, req_ready);
        end
        step();
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h4) begin
            tests_failed++;
            $display("FAIL b2b_third: got v=%b %h want v=1 00000004", rsp_valid, rsp_result);
        end
        step();
        exp_cnt += 3;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_count !== 8'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL b2b_drain: got v=%b cnt=%0d want v=0 cnt=%0d", rsp_valid, rsp_count, exp_cnt);
        end
    endtask

    task automatic test_count_wrap();
        int k;
        int bad;
        k   = 256 - exp_cnt;
        bad = 0;
        rsp_ready = 1'b1;
        req_op    = 2'b01;
        req_b     = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < k; i++) begin
            req_a = 32'(i);
            step();
            if (bad == 0 && (rsp_valid !== 1'b1 || rsp_result !== 32'(i))) begin
                bad = 1;
                tests_run++;
                tests_failed++;
                $display("FAIL stream_order[%0d]: got v=%b %h want v=1 %h", i, rsp_valid, rsp_result, 32'(i));
            end
        end
        if (bad == 0) begin
            tests_run++;
        end
        req_valid = 1'b0;
        step();
        tests_run++;
        if (rsp_count !== 8'd0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL count_wrap: got cnt=%0d v=%b want cnt=0 v=0", rsp_count, rsp_valid);
        end
        step();
        tests_run++;
        if (rsp_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL ready_without_valid: got cnt=%0d want 0", rsp_count);
        end
        exp_cnt = 0;
    endtask

    task automatic test_reset_when_full();
        rsp_ready = 1'b0;
        req_op    = 2'b10;
        req_b     = 32'h0;
        req_valid = 1'b1;
        req_a     = 32'h0000_0011;
        step();
        req_a = 32'h0000_0022;
        step();
        tests_run++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 32'h11) begin
            tests_failed++;
            $display("FAIL full_before_reset: got rdy=%b v=%b %h want rdy=0 v=1 00000011",
                     req_ready, rsp_valid, rsp_result);
        end
        rst_n = 1'b0;
        req_a = 32'h0000_0033;
        step();
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_count !== 8'd0 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_reset: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=0",
                     rsp_valid, rsp_count, req_ready);
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready: got %b want 1", req_ready);
        end
        step();
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL no_stale_rsp: got v=%b cnt=%0d want v=0 cnt=0", rsp_valid, rsp_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_a        = 32'h0;
        req_b        = 32'h0;
        rsp_ready    = 1'b0;
        #2;
        test_reset();
        test_orr_basic();
        test_logic_ops();
        test_back_to_back();
        test_count_wrap();
        test_reset_when_full();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
